// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode front end for the multicycle MIPS core.
// Fetches one word per FETCH phase over an Avalon-style read port, latches it
// into the instruction register (IR) and decodes IR into register addresses,
// immediates and one-hot jump/branch strobes for the PC unit.
//
// Ports:
//   clk, rst (async, active-low)
//   state            core phase from PC unit (0=FETCH 1=EXEC1 2=EXEC2)
//   pc               current PC
//   mem_address/mem_read/mem_waitrequest/mem_readdata  read master
//   stall            holds the core phase while a fetch is outstanding
//   fetch_error      sticky: misaligned PC or bus timeout (cleared by reset)
//   instr            IR contents; rs_addr/rt_addr/I_immediate/J_immediate fields
//   J..BGEZAL        decode strobes, at most one high, zero during FETCH/error
//
// Parameter MAX_WAIT: waitrequest cycles tolerated before fetch_error (1..255).
// Optional macro BYTE_SWAP_EN: byte-reverse the read word before loading IR
// (little-endian memory feeding the big-endian core).
module instr_fetch_decode #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic [31:0] pc,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        stall,
  output logic        fetch_error,
  output logic [31:0] instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [15:0] I_immediate,
  output logic [25:0] J_immediate,
  output logic        J,
  output logic        JAL,
  output logic        JR,
  output logic        JALR,
  output logic        BEQ,
  output logic        BNE,
  output logic        BLEZ,
  output logic        BGTZ,
  output logic        BLTZ,
  output logic        BGEZ,
  output logic        BLTZAL,
  output logic        BGEZAL
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ERROR   = 2'd3;

  logic [1:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      ir_load;
  logic [11:0]      strb;

  // Word as seen by the core
`ifdef BYTE_SWAP_EN
  assign ir_load = {mem_readdata[7:0], mem_readdata[15:8],
                    mem_readdata[23:16], mem_readdata[31:24]};
`else
  assign ir_load = mem_readdata;
`endif

  // State, wait counter and IR registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= S_IDLE;
      cnt_q <= '0;
      ir_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      ir_q  <= ir_d;
    end
  end

  // Next-state: one read per FETCH phase; acceptance on the last allowed
  // wait cycle takes priority over the timeout.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    ir_d  = ir_q;
    case (fsm_q)
      S_IDLE: begin
        if (state == 2'd0) begin
          fsm_d = (pc[1:0] != 2'b00) ? S_ERROR : S_REQ;
        end
      end
      S_REQ: begin
        if (!mem_waitrequest) begin
          fsm_d = S_CAPTURE;
        end else if (cnt_q == WAIT_LAST) begin
          fsm_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        ir_d  = ir_load;
        cnt_d = '0;
        fsm_d = S_IDLE;
      end
      S_ERROR: fsm_d = S_ERROR;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Bus and status outputs decoded from the state register
  assign mem_address = {pc[31:2], 2'b00};
  assign mem_read    = (fsm_q == S_REQ);
  assign fetch_error = (fsm_q == S_ERROR);
  assign stall       = ((state == 2'd0) && (fsm_q != S_CAPTURE)) || (fsm_q == S_ERROR);

  // IR fields
  assign instr       = ir_q;
  assign rs_addr     = ir_q[25:21];
  assign rt_addr     = ir_q[20:16];
  assign I_immediate = ir_q[15:0];
  assign J_immediate = ir_q[25:0];

  // One-hot jump/branch decode, suppressed during FETCH and after an error
  always_comb begin
    strb = '0;
    if ((state != 2'd0) && (fsm_q != S_ERROR)) begin
      case (ir_q[31:26])
        6'h00: begin
          case (ir_q[5:0])
            6'h08:   strb[9]  = 1'b1;
            6'h09:   strb[8]  = 1'b1;
            default: strb     = '0;
          endcase
        end
        6'h01: begin
          case (ir_q[20:16])
            5'h00:   strb[3]  = 1'b1;
            5'h01:   strb[2]  = 1'b1;
            5'h10:   strb[1]  = 1'b1;
            5'h11:   strb[0]  = 1'b1;
            default: strb     = '0;
          endcase
        end
        6'h02:   strb[11] = 1'b1;
        6'h03:   strb[10] = 1'b1;
        6'h04:   strb[7]  = 1'b1;
        6'h05:   strb[6]  = 1'b1;
        6'h06:   strb[5]  = 1'b1;
        6'h07:   strb[4]  = 1'b1;
        default: strb     = '0;
      endcase
    end
  end

  assign {J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL} = strb;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized self-checking bench for instr_fetch_decode. The bench plays the
// PC unit (drives state) and the memory slave, and checks each fetch
// transaction against a reference model of the expected bus behaviour and
// decode result.
module tb_instr_fetch_decode;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        stall;
  logic        fetch_error;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [15:0] I_immediate;
  logic [25:0] J_immediate;
  logic        J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL;
  logic [11:0] strobes;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_decode #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .state(state), .pc(pc),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .stall(stall), .fetch_error(fetch_error), .instr(instr),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .I_immediate(I_immediate), .J_immediate(J_immediate),
    .J(J), .JAL(JAL), .JR(JR), .JALR(JALR), .BEQ(BEQ), .BNE(BNE),
    .BLEZ(BLEZ), .BGTZ(BGTZ), .BLTZ(BLTZ), .BGEZ(BGEZ),
    .BLTZAL(BLTZAL), .BGEZAL(BGEZAL)
  );

  assign strobes = {J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Word the core should see after a fetch of 'data'
  function automatic logic [31:0] ref_ir(input logic [31:0] data);
`ifdef BYTE_SWAP_EN
    return {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
    return data;
`endif
  endfunction

  // Expected strobe vector, ordered J,JAL,JR,JALR,BEQ,BNE,BLEZ,BGTZ,BLTZ,BGEZ,BLTZAL,BGEZAL
  function automatic logic [11:0] ref_strobes(input logic [31:0] ir, input logic [1:0] st,
                                              input bit err);
    int op = int'(ir[31:26]);
    int rt = int'(ir[20:16]);
    int fn = int'(ir[5:0]);
    int k  = -1;
    logic [11:0] v = '0;
    if (st == 2'd0 || err) return v;
    if (op == 2) k = 0;
    else if (op == 3) k = 1;
    else if (op == 0 && fn == 8) k = 2;
    else if (op == 0 && fn == 9) k = 3;
    else if (op >= 4 && op <= 7) k = op;
    else if (op == 1 && rt == 0) k = 8;
    else if (op == 1 && rt == 1) k = 9;
    else if (op == 1 && rt == 16) k = 10;
    else if (op == 1 && rt == 17) k = 11;
    if (k >= 0) v[11-k] = 1'b1;
    return v;
  endfunction

  // Instruction generator biased toward the decoded encodings and their neighbours
  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int pick = $urandom_range(0, 9);
    int r;
    case (pick)
      0: begin w[31:26] = 6'd0; w[5:0] = ($urandom_range(0, 1) != 0) ? 6'h08 : 6'h09; end
      1: w[31:26] = 6'd0;
      2: begin
        w[31:26] = 6'd1;
        r = $urandom_range(0, 3);
        w[20:16] = (r < 2) ? 5'(r) : 5'(r + 14);
      end
      3: w[31:26] = 6'd1;
      4, 5, 6, 7, 8: w[31:26] = 6'($urandom_range(2, 7));
      default: ;
    endcase
    return w;
  endfunction

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq({tag, "_rst_rd"}, 64'(mem_read), 64'd0);
    check_eq({tag, "_rst_err"}, 64'(fetch_error), 64'd0);
    check_eq({tag, "_rst_ir"}, 64'(instr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One FETCH phase followed by EXEC1/EXEC2, with nwait waitrequest cycles
  task automatic do_fetch(input logic [31:0] a_pc, input int nwait, input logic [31:0] data);
    int  reqs    = 0;
    int  stalls  = 0;
    bit  done    = 0;
    bit  addr_ok = 1;
    bit  st_ok   = 1;
    bit  misal   = (a_pc[1:0] != 2'b00);
    bit  exp_err = misal || (nwait >= int'(MAX_WAIT));
    logic [31:0] exp_ir = ref_ir(data);
    @(negedge clk);
    state = 2'd0; pc = a_pc; mem_waitrequest = 1'b1; mem_readdata = $urandom;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (mem_read) begin
        reqs++;
        stalls++;
        if (mem_address !== {a_pc[31:2], 2'b00}) addr_ok = 0;
        if (!stall) st_ok = 0;
        mem_waitrequest = (reqs <= nwait);
        mem_readdata = (reqs <= nwait) ? $urandom : data;
      end else if (reqs > 0 || fetch_error) begin
        done = 1;
      end else begin
        stalls += int'(stall);
      end
      if (!done) @(negedge clk);
    end
    check_eq("fetch_done", 64'(done), 64'd1);
    check_eq("read_addr", 64'(addr_ok), 64'd1);
    check_eq("req_stall", 64'(st_ok), 64'd1);
    if (exp_err) begin
      check_eq("err_flag", 64'(fetch_error), 64'd1);
      check_eq("err_rd", 64'(mem_read), 64'd0);
      check_eq("err_stall", 64'(stall), 64'd1);
      check_eq("err_reqs", 64'(reqs), misal ? 64'd0 : 64'(MAX_WAIT));
      state = 2'd1;
      #1;
      check_eq("err_strobes", 64'(strobes), 64'd0);
      check_eq("err_stall_exec", 64'(stall), 64'd1);
      pulse_reset("err");
      check_eq("post_rst_stall", 64'(stall), 64'd0);
    end else begin
      check_eq("cap_stall", 64'(stall), 64'd0);
      check_eq("cap_err", 64'(fetch_error), 64'd0);
      check_eq("req_cycles", 64'(reqs), 64'(nwait + 1));
      check_eq("stall_cycles", 64'(stalls), 64'(nwait + 2));
      @(posedge clk);
      #1 state = 2'd1;
      @(negedge clk);
      check_eq("ir", 64'(instr), 64'(exp_ir));
      check_eq("rs", 64'(rs_addr), 64'(exp_ir[25:21]));
      check_eq("rt", 64'(rt_addr), 64'(exp_ir[20:16]));
      check_eq("iimm", 64'(I_immediate), 64'(exp_ir[15:0]));
      check_eq("jimm", 64'(J_immediate), 64'(exp_ir[25:0]));
      check_eq("strobes_e1", 64'(strobes), 64'(ref_strobes(exp_ir, 2'd1, 1'b0)));
      check_eq("e1_rd", 64'(mem_read), 64'd0);
      check_eq("e1_stall", 64'(stall), 64'd0);
      state = 2'd2;
      #1;
      check_eq("strobes_e2", 64'(strobes), 64'(ref_strobes(exp_ir, 2'd2, 1'b0)));
      @(negedge clk);
      check_eq("e2_rd", 64'(mem_read), 64'd0);
      check_eq("e2_ir_hold", 64'(instr), 64'(exp_ir));
    end
  endtask

  // Reset asserted while a read is pending
  task automatic rst_mid_req();
    @(negedge clk);
    state = 2'd0; pc = 32'h0000_0200; mem_waitrequest = 1'b1;
    for (int i = 0; i < 8 && !mem_read; i++) @(negedge clk);
    check_eq("mid_req_rd", 64'(mem_read), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_rd", 64'(mem_read), 64'd0);
    check_eq("mid_rst_ir", 64'(instr), 64'd0);
    check_eq("mid_rst_err", 64'(fetch_error), 64'd0);
    @(negedge clk);
    state = 2'd1; mem_waitrequest = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    int nw;
    rst = 1'b0; state = 2'd1; pc = '0; mem_waitrequest = 1'b0; mem_readdata = '0;
    @(negedge clk);
    check_eq("reset_rd", 64'(mem_read), 64'd0);
    check_eq("reset_err", 64'(fetch_error), 64'd0);
    check_eq("reset_ir", 64'(instr), 64'd0);
    check_eq("reset_strobes", 64'(strobes), 64'd0);
    rst = 1'b1;

    do_fetch(32'h0000_0100, 0, 32'h0800_0040);
    do_fetch(32'h0000_0104, 3, 32'h0411_FFFE);
    do_fetch(32'h0000_0108, 0, 32'h0000_F809);
    do_fetch(32'h0000_010C, 1, 32'h0000_0020);
    do_fetch(32'h0000_0110, int'(MAX_WAIT) - 1, 32'h1000_0010);
    do_fetch(32'h0000_0114, 0, 32'h4000_0008);
    rst_mid_req();
    do_fetch(32'h0000_0120, int'(MAX_WAIT), 32'h0800_0001);
    do_fetch(32'h0000_0102, 0, 32'h0800_0001);

    for (int t = 0; t < 40; t++) begin
      rpc = $urandom;
      if ($urandom_range(0, 9) != 0) rpc[1:0] = 2'b00;
      nw = $urandom_range(0, int'(MAX_WAIT));
      do_fetch(rpc, nw, rand_instr());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
